// File: rtl/multicycle_ctrl_hs.sv
// Multicycle MIPS control FSM with a memory ready handshake and bus timeout.
// Moore outputs decoded from state; only the fetch write strobes and the pulses also look at mem_ready.
module multicycle_ctrl_hs #(
    parameter int ALU_W       = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             mem_ready,
    output logic [ALU_W-1:0] alu_control,
    output logic             alu_src_a,
    output logic [2:0]       alu_src_b,
    output logic [1:0]       pc_src,
    output logic             pc_write,
    output logic             branch,
    output logic             branch_ne,
    output logic             reg_write,
    output logic             i_or_d,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_req,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             bus_err,
    output logic             illegal,
    output logic             retire,
    output logic [3:0]       fsm_state
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC, S_ALUWB,
        S_IEXS, S_IEXZ, S_IWB, S_BRANCH, S_JUMP, S_JR, S_JAL
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_SLTI = 6'h0A;
    localparam logic [5:0] OP_ANDI = 6'h0C;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI = 6'h0E;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] FN_JR   = 6'h08;

    localparam logic [ALU_W-1:0] ALU_AND = ALU_W'(1);
    localparam logic [ALU_W-1:0] ALU_OR  = ALU_W'(2);
    localparam logic [ALU_W-1:0] ALU_XOR = ALU_W'(3);
    localparam logic [ALU_W-1:0] ALU_NOR = ALU_W'(4);
    localparam logic [ALU_W-1:0] ALU_ADD = ALU_W'(5);
    localparam logic [ALU_W-1:0] ALU_SUB = ALU_W'(6);
    localparam logic [ALU_W-1:0] ALU_SLT = ALU_W'(7);

    localparam bit               TO_EN     = (MEM_TIMEOUT > 0);
    localparam int               TO_LAST_I = TO_EN ? MEM_TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TO_LAST_I);

    state_t               state, state_next;
    logic [CNT_W-1:0]     cnt;
    logic                 is_mem;
    logic                 timeout_hit;
    logic                 r_ok;
    logic [ALU_W-1:0]     r_alu;

    assign fsm_state   = state;
    assign is_mem      = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign timeout_hit = TO_EN && is_mem && !mem_ready && (cnt == TO_LAST);

    // R-type funct decode; jr is legal here but takes its own path out of DECODE.
    always_comb begin
        r_ok  = 1'b1;
        r_alu = '0;
        case (funct)
            6'h20:   r_alu = ALU_ADD;
            6'h22:   r_alu = ALU_SUB;
            6'h24:   r_alu = ALU_AND;
            6'h25:   r_alu = ALU_OR;
            6'h26:   r_alu = ALU_XOR;
            6'h27:   r_alu = ALU_NOR;
            6'h2A:   r_alu = ALU_SLT;
            FN_JR:   r_alu = '0;
            default: r_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_next;
            // Counts only while parked in a memory state; any exit, ready or timeout restarts it.
            if (is_mem && !mem_ready && !timeout_hit && (state_next == state))
                cnt <= cnt + CNT_W'(1);
            else
                cnt <= '0;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)        state_next = S_DECODE;
                else if (timeout_hit) state_next = S_FETCH;
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:              state_next = S_MEMADR;
                    OP_R:                      state_next = !r_ok ? S_FETCH :
                                                            (funct == FN_JR) ? S_JR : S_EXEC;
                    OP_ADDI, OP_SLTI:          state_next = S_IEXS;
                    OP_ANDI, OP_ORI, OP_XORI:  state_next = S_IEXZ;
                    OP_BEQ, OP_BNE:            state_next = S_BRANCH;
                    OP_J:                      state_next = S_JUMP;
                    OP_JAL:                    state_next = S_JAL;
                    default:                   state_next = S_FETCH;
                endcase
            end
            S_MEMADR: state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready)        state_next = S_MEMWB;
                else if (timeout_hit) state_next = S_FETCH;
            end
            S_MEMWR:  if (mem_ready || timeout_hit) state_next = S_FETCH;
            S_EXEC:   state_next = S_ALUWB;
            S_IEXS:   state_next = S_IWB;
            S_IEXZ:   state_next = S_IWB;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        alu_control = '0;
        alu_src_a   = 1'b0;
        alu_src_b   = 3'd0;
        pc_src      = 2'd0;
        pc_write    = 1'b0;
        branch      = 1'b0;
        branch_ne   = 1'b0;
        reg_write   = 1'b0;
        i_or_d      = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        mem_req     = 1'b0;
        reg_dst     = 2'd0;
        mem_to_reg  = 2'd0;
        bus_err     = 1'b0;
        illegal     = 1'b0;
        retire      = 1'b0;
        if (rstb) begin
            bus_err = timeout_hit;
            case (state)
                S_FETCH: begin
                    mem_req     = 1'b1;
                    alu_src_b   = 3'd1;
                    alu_control = ALU_ADD;
                    ir_write    = mem_ready;
                    pc_write    = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b   = 3'd3;
                    alu_control = ALU_ADD;
                    illegal     = (state_next == S_FETCH);
                end
                S_MEMADR: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 3'd2;
                    alu_control = ALU_ADD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    i_or_d  = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'd1;
                    retire     = 1'b1;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    retire    = mem_ready;
                end
                S_EXEC: begin
                    alu_src_a   = 1'b1;
                    alu_control = r_alu;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 2'd1;
                    retire    = 1'b1;
                end
                S_IEXS: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 3'd2;
                    alu_control = (op == OP_SLTI) ? ALU_SLT : ALU_ADD;
                end
                S_IEXZ: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 3'd4;
                    alu_control = (op == OP_ANDI) ? ALU_AND :
                                  (op == OP_ORI)  ? ALU_OR  : ALU_XOR;
                end
                S_IWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a   = 1'b1;
                    alu_control = ALU_SUB;
                    pc_src      = 2'd1;
                    branch      = (op == OP_BEQ);
                    branch_ne   = (op == OP_BNE);
                    retire      = 1'b1;
                end
                S_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                    retire   = 1'b1;
                end
                S_JR: begin
                    pc_write = 1'b1;
                    pc_src   = 2'd3;
                    retire   = 1'b1;
                end
                S_JAL: begin
                    pc_write   = 1'b1;
                    pc_src     = 2'd2;
                    reg_write  = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                    retire     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_hs.sv
// Bench for multicycle_ctrl_hs: per-instruction step tables drive a cycle model that is
// compared against every DUT output each cycle, plus literal spot checks on directed cases.
module tb_multicycle_ctrl_hs;

    localparam int TB_TO = 4;
    localparam int NEVER = 99;

    typedef struct packed {
        logic [3:0] alu;
        logic       sa;
        logic [2:0] sb;
        logic [1:0] ps;
        logic       pcw, br, bne, rw, iod, mw, irw, mreq;
        logic [1:0] rd, mtr;
        logic       berr, ill, ret;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  mem;
        logic  fetch;
    } step_t;

    logic       clk = 1'b0;
    logic       rstb;
    logic [5:0] op, funct;
    logic       mem_ready;
    logic [3:0] alu_control;
    logic       alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write, branch, branch_ne, reg_write, i_or_d, mem_write, ir_write, mem_req;
    logic [1:0] reg_dst, mem_to_reg;
    logic       bus_err, illegal, retire;
    logic [3:0] fsm_state;

    outs_t dut_o;
    outs_t exp_o;
    bit    chk_en;
    int    total, bad;
    int    dut_retires;
    outs_t snap[$];
    step_t steps[$];

    multicycle_ctrl_hs #(.ALU_W(4), .MEM_TIMEOUT(TB_TO), .CNT_W(5)) dut (
        .clk(clk), .rstb(rstb), .op(op), .funct(funct), .mem_ready(mem_ready),
        .alu_control(alu_control), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .pc_write(pc_write), .branch(branch), .branch_ne(branch_ne),
        .reg_write(reg_write), .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write),
        .mem_req(mem_req), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .bus_err(bus_err),
        .illegal(illegal), .retire(retire), .fsm_state(fsm_state)
    );

    assign dut_o = {alu_control, alu_src_a, alu_src_b, pc_src, pc_write, branch, branch_ne,
                    reg_write, i_or_d, mem_write, ir_write, mem_req, reg_dst, mem_to_reg,
                    bus_err, illegal, retire};

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // Scoreboard compare: one check per meaningful cycle, away from the rising edge.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            snap.push_back(dut_o);
            if (dut_o.ret) dut_retires++;
            if (dut_o !== exp_o) begin
                bad++;
                $display("FAIL outputs op=%h funct=%h got=%h want=%h", op, funct, dut_o, exp_o);
            end
        end
    end

    task automatic lit(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic bit legal(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h23, 6'h2B, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h04, 6'h05, 6'h02, 6'h03: return 1'b1;
            6'h00: return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h08};
            default: return 1'b0;
        endcase
    endfunction

    // Step table of one instruction, from fetch through its retiring (or illegal) cycle.
    task automatic build_steps(input logic [5:0] o, input logic [5:0] f);
        step_t s;
        steps.delete();
        s = '0; s.o.mreq = 1; s.o.alu = 5; s.o.sb = 1; s.mem = 1; s.fetch = 1;
        steps.push_back(s);
        s = '0; s.o.alu = 5; s.o.sb = 3;
        if (!legal(o, f)) begin
            s.o.ill = 1;
            steps.push_back(s);
            return;
        end
        steps.push_back(s);
        s = '0;
        case (o)
            6'h23, 6'h2B: begin
                s.o.sa = 1; s.o.sb = 2; s.o.alu = 5; steps.push_back(s);
                s = '0; s.o.mreq = 1; s.o.iod = 1; s.mem = 1;
                if (o == 6'h2B) begin
                    s.o.mw = 1; steps.push_back(s);
                end else begin
                    steps.push_back(s);
                    s = '0; s.o.rw = 1; s.o.mtr = 1; s.o.ret = 1; steps.push_back(s);
                end
            end
            6'h00: begin
                if (f == 6'h08) begin
                    s.o.pcw = 1; s.o.ps = 3; s.o.ret = 1; steps.push_back(s);
                end else begin
                    s.o.sa = 1;
                    case (f)
                        6'h20: s.o.alu = 5;  6'h22: s.o.alu = 6;  6'h24: s.o.alu = 1;
                        6'h25: s.o.alu = 2;  6'h26: s.o.alu = 3;  6'h27: s.o.alu = 4;
                        default: s.o.alu = 7;
                    endcase
                    steps.push_back(s);
                    s = '0; s.o.rw = 1; s.o.rd = 1; s.o.ret = 1; steps.push_back(s);
                end
            end
            6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
                s.o.sa = 1;
                case (o)
                    6'h08: begin s.o.sb = 2; s.o.alu = 5; end
                    6'h0A: begin s.o.sb = 2; s.o.alu = 7; end
                    6'h0C: begin s.o.sb = 4; s.o.alu = 1; end
                    6'h0D: begin s.o.sb = 4; s.o.alu = 2; end
                    default: begin s.o.sb = 4; s.o.alu = 3; end
                endcase
                steps.push_back(s);
                s = '0; s.o.rw = 1; s.o.ret = 1; steps.push_back(s);
            end
            6'h04, 6'h05: begin
                s.o.sa = 1; s.o.alu = 6; s.o.ps = 1; s.o.ret = 1;
                s.o.br = (o == 6'h04); s.o.bne = (o == 6'h05);
                steps.push_back(s);
            end
            6'h02: begin
                s.o.pcw = 1; s.o.ps = 2; s.o.ret = 1; steps.push_back(s);
            end
            default: begin
                s.o.pcw = 1; s.o.ps = 2; s.o.rw = 1; s.o.rd = 2; s.o.mtr = 2; s.o.ret = 1;
                steps.push_back(s);
            end
        endcase
    endtask

    // Driver + model: ready after lat waiting cycles; timeout, illegal or reset ends the instruction.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int lat_f, input int lat_m, input int rst_at);
        step_t s;
        outs_t e;
        int    w, idx, guard, lat;
        bit    rdy, to;
        build_steps(o, f);
        snap.delete();
        op = o; funct = f;
        w = 0; idx = 0; guard = 0;
        while (steps.size() > 0) begin
            s   = steps[0];
            e   = s.o;
            lat = s.fetch ? lat_f : lat_m;
            rdy = s.mem ? (w == lat) : 1'($urandom_range(0, 1));
            to  = 1'b0;
            if (s.mem) begin
                to = (TB_TO > 0) && (w == TB_TO - 1) && !rdy;
                if (s.fetch) begin e.irw = rdy; e.pcw = rdy; end
                if (steps.size() == 1) e.ret = rdy;
                e.berr = to;
            end
            if (idx == rst_at && w == 0) begin
                rstb = 1'b0; rdy = 1'b0; e = '0;
            end
            mem_ready = rdy;
            exp_o     = e;
            chk_en    = 1'b1;
            @(posedge clk); #1;
            if (!rstb) begin
                rstb = 1'b1;
                return;
            end
            if (to) return;
            if (s.mem && !rdy) w++;
            else begin
                void'(steps.pop_front());
                w = 0; idx++;
            end
            guard++;
            if (guard > 64) begin
                lit("instr_cycle_budget", guard, 64);
                return;
            end
        end
    endtask

    logic [5:0] op_tab [12] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h0A, 6'h0C,
                                6'h0D, 6'h0E, 6'h04, 6'h05, 6'h02, 6'h03};
    logic [5:0] fn_tab [8]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h08};

    initial begin
        int r0, cnt_mw, cnt_w;
        logic [5:0] o, f;
        total = 0; bad = 0; dut_retires = 0;
        rstb = 1'b0; op = '0; funct = '0; mem_ready = 1'b0; chk_en = 1'b0; exp_o = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        repeat (3) begin
            mem_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        rstb = 1'b1;

        // lw with each access ready two cycles late
        r0 = dut_retires;
        run_instr(6'h23, 6'h00, 2, 2, -1);
        lit("lw_cycles", snap.size(), 9);
        lit("lw_retires", dut_retires - r0, 1);
        lit("lw_fetch_wait_irw", int'(snap[1].irw), 0);
        lit("lw_fetch_ready_irw", int'(snap[2].irw), 1);
        lit("lw_memwb_mtr", int'(snap[8].mtr), 1);

        run_instr(6'h00, 6'h22, 0, 0, -1);
        lit("sub_cycles", snap.size(), 4);
        lit("sub_alu", int'(snap[2].alu), 6);
        lit("sub_sb", int'(snap[2].sb), 0);
        lit("sub_wb_rd", int'(snap[3].rd), 1);
        lit("sub_wb_rw", int'(snap[3].rw), 1);

        run_instr(6'h0D, 6'h00, 0, 0, -1);
        lit("ori_sb", int'(snap[2].sb), 4);
        lit("ori_alu", int'(snap[2].alu), 2);

        run_instr(6'h05, 6'h00, 1, 0, -1);
        lit("bne_bne", int'(snap[3].bne), 1);
        lit("bne_br", int'(snap[3].br), 0);
        lit("bne_ps", int'(snap[3].ps), 1);

        run_instr(6'h03, 6'h00, 0, 0, -1);
        lit("jal_flags", {snap[2].ps, snap[2].rd, snap[2].mtr, snap[2].rw}, 7'b10_10_10_1);

        run_instr(6'h00, 6'h08, 0, 0, -1);
        lit("jr_ps", int'(snap[2].ps), 3);

        // sw whose memory never answers
        r0 = dut_retires;
        run_instr(6'h2B, 6'h00, 0, NEVER, -1);
        cnt_mw = 0; cnt_w = 0;
        foreach (snap[i]) begin
            cnt_mw += int'(snap[i].mw);
            if (i > 0) cnt_w += int'(snap[i].pcw);
        end
        lit("sw_to_cycles", snap.size(), 7);
        lit("sw_to_mem_write_cycles", cnt_mw, 4);
        lit("sw_to_bus_err", int'(snap[6].berr), 1);
        lit("sw_to_pc_write", cnt_w, 0);
        lit("sw_to_retires", dut_retires - r0, 0);

        run_instr(6'h3F, 6'h00, 0, 0, -1);
        lit("ill_cycles", snap.size(), 2);
        lit("ill_pulse", int'(snap[1].ill), 1);
        lit("ill_writes", {snap[1].rw, snap[1].mw, snap[1].pcw, snap[1].irw}, 0);

        run_instr(6'h23, 6'h00, 0, NEVER, 3);
        lit("rst_memrd_outputs", int'(snap[3]), 0);

        // fetch right after the reset must start clean
        run_instr(6'h02, 6'h00, 3, 0, -1);
        lit("post_rst_jump_cycles", snap.size(), 6);

        repeat (200) begin
            o = op_tab[$urandom_range(0, 11)];
            if ($urandom_range(0, 9) == 0) o = 6'($urandom_range(0, 63));
            f = fn_tab[$urandom_range(0, 7)];
            if ($urandom_range(0, 4) == 0) f = 6'($urandom_range(0, 63));
            run_instr(o, f, $urandom_range(0, 5), $urandom_range(0, 5),
                      ($urandom_range(0, 19) == 0) ? $urandom_range(0, 3) : -1);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
